// File: rtl/rv32_pipe_pkg.sv
// rtl/rv32_pipe_pkg.sv - shared constants and entry type for the RV32 pipeline stage
package rv32_pipe_pkg;

    localparam logic [31:0] RV32_NOP      = 32'h0000_0013;
    localparam int          DEF_XLEN      = 32;
    localparam int          DEF_NUM_LANES = 4;
    localparam int          DEF_CTRL_W    = 3;
    localparam int          DEF_RSEL_W    = 5;

    typedef struct packed {
        logic [DEF_NUM_LANES*DEF_XLEN-1:0] data;
        logic [DEF_CTRL_W-1:0]             ctrl;
        logic                              hlt;
        logic [31:0]                       code;
        logic [DEF_RSEL_W-1:0]             rd;
    } pipe_entry_t;

endpackage

// File: rtl/rv32_pipe_entry.sv
// rtl/rv32_pipe_entry.sv - one valid+payload slot with load, clear and bubble controls
module rv32_pipe_entry
    import rv32_pipe_pkg::*;
#(
    parameter int DW     = DEF_NUM_LANES * DEF_XLEN,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int RSEL_W = DEF_RSEL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic              bubble_i,
    input  logic [DW-1:0]     data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic              hlt_i,
    input  logic [31:0]       code_i,
    input  logic [RSEL_W-1:0] rd_i,
    output logic              valid_o,
    output logic [DW-1:0]     data_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              hlt_o,
    output logic [31:0]       code_o,
    output logic [RSEL_W-1:0] rd_o
);

    logic              valid_q, valid_d;
    logic [DW-1:0]     data_q, data_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              hlt_q, hlt_d;
    logic [31:0]       code_q, code_d;
    logic [RSEL_W-1:0] rd_q, rd_d;

    // A bubble turns the slot into a side-effect-free NOP but leaves the data lanes alone.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        hlt_d   = hlt_q;
        code_d  = code_q;
        rd_d    = rd_q;
        if (bubble_i) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            hlt_d   = 1'b0;
            code_d  = RV32_NOP;
            rd_d    = '0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            ctrl_d  = ctrl_i;
            hlt_d   = hlt_i;
            code_d  = code_i;
            rd_d    = rd_i;
        end else if (clear_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
            hlt_q   <= 1'b1;
            code_q  <= RV32_NOP;
            rd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            hlt_q   <= hlt_d;
            code_q  <= code_d;
            rd_q    <= rd_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign ctrl_o  = ctrl_q;
    assign hlt_o   = hlt_q;
    assign code_o  = code_q;
    assign rd_o    = rd_q;

endmodule

// File: rtl/rv32_pipe_skid_stage.sv
// rtl/rv32_pipe_skid_stage.sv - registered valid/ready pipeline stage with optional skid slot
module rv32_pipe_skid_stage
    import rv32_pipe_pkg::*;
#(
    parameter int XLEN      = DEF_XLEN,
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int CTRL_W    = DEF_CTRL_W,
    parameter int RSEL_W    = DEF_RSEL_W,
    parameter int SKID      = 1,
    parameter int CNT_W     = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_LANES*XLEN-1:0] in_data,
    input  logic [CTRL_W-1:0]         in_ctrl,
    input  logic                      in_hlt,
    input  logic [31:0]               in_code,
    input  logic [RSEL_W-1:0]         in_rd,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_LANES*XLEN-1:0] out_data,
    output logic [CTRL_W-1:0]         out_ctrl,
    output logic                      out_hlt,
    output logic [31:0]               out_code,
    output logic [RSEL_W-1:0]         out_rd,
    output logic [1:0]                occupancy,
    output logic [CNT_W-1:0]          stall_cycles
);

    localparam int DW = NUM_LANES * XLEN;

    logic              accept, drain, rdy_raw;
    logic              m_v, m_load, m_clr, s_v;
    logic [DW-1:0]     m_data, s_data, m_src_data;
    logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_src_ctrl;
    logic              m_hlt, s_hlt, m_src_hlt;
    logic [31:0]       m_code, s_code, m_src_code;
    logic [RSEL_W-1:0] m_rd, s_rd, m_src_rd;
    logic [CNT_W-1:0]  stall_q, stall_d;

    assign in_ready = rst_n & rdy_raw;
    assign accept   = in_valid & in_ready;
    assign drain    = m_v & out_ready;

    // M refills from S whenever S holds the older entry, otherwise from the input.
    assign m_src_data = s_v ? s_data : in_data;
    assign m_src_ctrl = s_v ? s_ctrl : in_ctrl;
    assign m_src_hlt  = s_v ? s_hlt  : in_hlt;
    assign m_src_code = s_v ? s_code : in_code;
    assign m_src_rd   = s_v ? s_rd   : in_rd;

    generate
        if (SKID != 0) begin : g_skid
            logic s_load, s_clr;

            // Ready depends only on S being empty, so no out_ready->in_ready path exists.
            assign rdy_raw = ~s_v;
            assign m_load  = s_v ? drain : (accept & (~m_v | drain));
            assign m_clr   = drain & ~m_load;
            assign s_load  = accept & m_v & ~drain;
            assign s_clr   = s_v & drain;

            rv32_pipe_entry #(.DW(DW), .CTRL_W(CTRL_W), .RSEL_W(RSEL_W)) u_s (
                .clk      (clk),
                .rst_n    (rst_n),
                .load_i   (s_load),
                .clear_i  (s_clr),
                .bubble_i (flush),
                .data_i   (in_data),
                .ctrl_i   (in_ctrl),
                .hlt_i    (in_hlt),
                .code_i   (in_code),
                .rd_i     (in_rd),
                .valid_o  (s_v),
                .data_o   (s_data),
                .ctrl_o   (s_ctrl),
                .hlt_o    (s_hlt),
                .code_o   (s_code),
                .rd_o     (s_rd)
            );
        end else begin : g_single
            assign rdy_raw = ~m_v | out_ready;
            assign m_load  = accept;
            assign m_clr   = drain & ~accept;
            assign s_v     = 1'b0;
            assign s_data  = '0;
            assign s_ctrl  = '0;
            assign s_hlt   = 1'b0;
            assign s_code  = RV32_NOP;
            assign s_rd    = '0;
        end
    endgenerate

    rv32_pipe_entry #(.DW(DW), .CTRL_W(CTRL_W), .RSEL_W(RSEL_W)) u_m (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (m_load),
        .clear_i  (m_clr),
        .bubble_i (flush),
        .data_i   (m_src_data),
        .ctrl_i   (m_src_ctrl),
        .hlt_i    (m_src_hlt),
        .code_i   (m_src_code),
        .rd_i     (m_src_rd),
        .valid_o  (m_v),
        .data_o   (m_data),
        .ctrl_o   (m_ctrl),
        .hlt_o    (m_hlt),
        .code_o   (m_code),
        .rd_o     (m_rd)
    );

    always_comb begin
        stall_d = stall_q;
        if (m_v && !out_ready && !(&stall_q)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign out_valid    = m_v;
    assign out_data     = m_data;
    assign out_ctrl     = m_v ? m_ctrl : '0;
    assign out_hlt      = m_hlt;
    assign out_code     = m_code;
    assign out_rd       = m_rd;
    assign occupancy    = {1'b0, m_v} + {1'b0, s_v};
    assign stall_cycles = stall_q;

endmodule
